// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ requesters, with at most BURST_LEN words written per grant.
// Optional feature macro: ARB_STALL_CNT_EN adds a 16-bit saturating counter
// (stall_cnt_o) of cycles in which the owner is blocked by a full FIFO.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]       ack_o,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [IDX_WIDTH-1:0]     owner_o,
  output logic                     busy_o,
  input  logic                     fifo_full_i,
  output logic                     fifo_wr_en_o,
  output logic [WIDTH-1:0]         fifo_wdata_o
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt_o
`endif
);

  // Burst counter only needs to reach BURST_LEN-1; release resets it.
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] owner_q, owner_d;
  logic [IDX_WIDTH-1:0] last_q, last_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0] pick;
  logic                 wr;
  logic [WIDTH-1:0]     wd [NUM_REQ];

  // Next index in round-robin order, wrapping at NUM_REQ-1.
  function automatic logic [IDX_WIDTH-1:0] rr_next(input logic [IDX_WIDTH-1:0] i);
    return (i == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : i + IDX_WIDTH'(1);
  endfunction

  // First requester after 'last', with 'last' itself searched at the very end.
  function automatic logic [IDX_WIDTH-1:0] rr_pick(input logic [NUM_REQ-1:0]   req,
                                                   input logic [IDX_WIDTH-1:0] last);
    logic [IDX_WIDTH-1:0] idx;
    logic [IDX_WIDTH-1:0] sel;
    logic                 found;
    idx   = last;
    sel   = '0;
    found = 1'b0;
    for (int n = 0; n < NUM_REQ; n++) begin
      idx = rr_next(idx);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign wd[k] = wdata_i[k*WIDTH +: WIDTH];
  end

  // A word moves only when the owner has one, the FIFO has room and we are not in reset.
  assign wr   = (state_q == GRANT) & req_i[owner_q] & ~fifo_full_i & ~rst_i;
  assign pick = rr_pick(req_i, last_q);

  assign fifo_wr_en_o = wr;
  assign ack_o        = wr ? (NUM_REQ'(1) << owner_q) : '0;
  assign fifo_wdata_o = (state_q == GRANT) ? wd[owner_q] : '0;
  assign gnt_o        = gnt_q;
  assign owner_o      = owner_q;
  assign busy_o       = (state_q == GRANT);

  // State, grant and burst-count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_WIDTH'(NUM_REQ - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbitration: grant from IDLE, count words, and re-pick in the release cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = GRANT;
          owner_d = pick;
          last_d  = pick;
          gnt_d   = NUM_REQ'(1) << pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (wr) cnt_d = cnt_q + CNT_W'(1);
        if ((wr && (cnt_q == CNT_LAST)) || !req_i[owner_q]) begin
          cnt_d = '0;
          if (|req_i) begin
            owner_d = pick;
            last_d  = pick;
            gnt_d   = NUM_REQ'(1) << pick;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ARB_STALL_CNT_EN
  logic [15:0] stall_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count cycles where the owner has a word but the FIFO is full.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if ((state_q == GRANT) && req_i[owner_q] && fifo_full_i) begin
      stall_q <= sat_inc16(stall_q);
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule
